rob_commit: RTL and testbench
=============================

# rob_commit

Reorder buffer with in-order retirement for the Tomasulo core. The issue stage allocates entries at the tail, and the execution units' common data bus (CDB) marks entries complete. This block retires completed entries from the head, one per cycle, and presents each retirement to the register bank and to the reservation-station occupancy counters. It is the consuming (head/retire) end of the ROB allocation protocol that the issue stage drives.

## Interface
Parameters:
- DEPTH, 8: number of ROB entries; must be a power of 2.
- TAG_W, 3: log2(DEPTH); width of an ROB index/tag.
- DATA_W, 16: result width.
- REG_W, 4: architectural register index width.
- FUNC_W, 4: function code width.

Ports:
- clk1  in  1  the only clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all entries.
- alloc_valid  in  1  issue requests an entry this cycle.
- alloc_func  in  FUNC_W  function code of the issuing instruction.
- alloc_rd  in  REG_W  destination register.
- alloc_ready  out  1  an entry is free (not full).
- alloc_tag  out  TAG_W  index that the next allocation receives (current tail).
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  TAG_W  ROB index of the result.
- cdb_data  in  DATA_W  result value.
- commit_valid  out  1  one-cycle pulse: an entry retired.
- commit_tag  out  TAG_W  index retired.
- commit_rd  out  REG_W  destination register of the retired entry.
- commit_data  out  DATA_W  value to write to the register bank.
- commit_func  out  FUNC_W  function code of the retired entry.
- commit_add  out  1  the retired entry was in the add class; decrements add_count.
- commit_mul  out  1  the retired entry was in the mul class; decrements mul_count.
- rob_count  out  TAG_W+1  occupied entries, 0..DEPTH.
- rob_empty  out  1  rob_count == 0.

## Operation
- Each entry holds: valid, ready, func, rd, data.
- Head and tail are TAG_W+1-bit pointers; the MSB is the wrap bit.
  - Empty: the pointers are equal.
  - Full: the index bits are equal and the wrap bits differ.
- Allocation:
  - An allocation happens when alloc_valid && alloc_ready.
  - It writes {valid=1, ready=0, func, rd} at the tail and increments the tail.
  - alloc_valid while full is ignored, with no state change.
- Writeback:
  - A writeback happens when cdb_valid hits an entry with valid=1 and ready=0.
  - It stores cdb_data and sets ready=1.
  - A CDB hit on an invalid or already-ready entry is ignored; data is never overwritten.
- Commit:
  - A commit happens when the head entry has valid && ready.
  - The entry's fields are registered onto the commit_* outputs with commit_valid=1.
  - The entry's valid bit is cleared and the head is incremented.
  - At most one commit per cycle, strictly in program order.
  - A head entry that is not ready blocks commit, even when younger entries are ready.
- Class decode:
  - func 0000/0001 → commit_add=1.
  - func 0010/0011 → commit_mul=1.
  - Any other func leaves both at 0.
  - Both strobes are valid only with commit_valid; otherwise they are 0.
- The register bank clears its rename tag for commit_rd only if that tag equals commit_tag. This block does not touch the register bank itself.
- rob_count = tail − head, modulo 2^(TAG_W+1).
- Priority: rst > flush > {alloc, cdb, commit}; the last three are independent within a cycle.
- Flush:
  - Clears all valid bits, sets head = tail = 0, and drives all outputs to their reset values.
  - The flush-cycle commit, alloc and CDB are discarded.

## Timing
- Reset values:
  - alloc_ready=1, alloc_tag=0, rob_count=0, rob_empty=1.
  - commit_valid=0, commit_tag=0, commit_rd=0, commit_data=0, commit_func=0, commit_add=0, commit_mul=0.
  - All entries are invalid.
- Reset or flush mid-operation takes effect at that edge; in-flight entries are lost.
- alloc_ready, alloc_tag, rob_count and rob_empty are registered-state functions. There is no same-cycle combinational path from any input.
- alloc_ready is 0 while full, even when a commit happens in the same cycle. Allocation resumes the cycle after the commit.
- CDB-to-commit latency: a CDB hit on the head sampled at edge N sets ready; commit happens at edge N+1, so commit_valid is high during cycle N+1. There is no CDB-to-commit bypass.
- Back-to-back commits are possible: one per cycle while successive head entries are ready.
- Simultaneous alloc and commit leave rob_count unchanged.
- Pointer wrap from index DEPTH−1 to 0 toggles the wrap bit.
- An alloc and a CDB hit on the same index in the same cycle is impossible: that index would be free, so the CDB hit is ignored.

## Test plan
- Reset, then 3 allocs (func 0000 rd 1; 0010 rd 2; 0001 rd 3) → alloc_tag 0,1,2; rob_count=3. CDB tag1=0x0022, then tag0=0x0011, then tag2=0x0033 → commits tag0/rd1/0x0011 with commit_add, then tag1/rd2/0x0022 with commit_mul, then tag2/rd3/0x0033 with commit_add, in order, on consecutive cycles.
- Fill with 8 allocs → alloc_ready=0, rob_count=8. A 9th alloc is ignored. CDB on the head plus an alloc in the same cycle → 1 commit, rob_count=7, and the alloc is not accepted.
- Wrap: 8 allocs, 8 commits, then 2 allocs → alloc_tag 0 then 1; the wrap bit toggles; rob_empty behaves correctly.
- CDB to invalid tag 5 and a repeated CDB to a ready entry with 0xFFFF → no state change, original data committed.
- Flush with 4 entries, 2 of them ready → next cycle rob_empty=1, alloc_tag=0, no commit_valid; rst mid-stream gives the same result.
- func 0100 committed → commit_valid=1, commit_add=0, commit_mul=0.

Source files
------------

// File: rtl/rob_commit.sv
// rob_commit: retire end of the reorder buffer.
//   Issue allocates entries at the tail, the CDB marks them complete, and
//   completed entries retire from the head one per cycle, in program order.
//
// Ports
//   clk1, rst          clock, synchronous active-high reset
//   flush              synchronous squash of every entry
//   alloc_valid/_func/_rd   allocation request from issue
//   alloc_ready        an entry is free
//   alloc_tag          index the next allocation receives
//   cdb_valid/_tag/_data    result broadcast
//   commit_*           registered retirement record (commit_valid is a pulse)
//   commit_add/_mul    class strobes for the reservation-station counters
//   rob_count          occupied entries, 0..DEPTH
//   rob_empty          rob_count == 0
module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int FUNC_W = 4
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              flush,
    input  logic              alloc_valid,
    input  logic [FUNC_W-1:0] alloc_func,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              commit_valid,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [REG_W-1:0]  commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic [FUNC_W-1:0] commit_func,
    output logic              commit_add,
    output logic              commit_mul,
    output logic [TAG_W:0]    rob_count,
    output logic              rob_empty
);

    localparam logic [TAG_W:0] PTR_ONE = (TAG_W+1)'(1);

    // Pointers carry an extra wrap bit above the index.
    logic [TAG_W:0]      r_head;
    logic [TAG_W:0]      r_tail;
    logic [DEPTH-1:0]    r_valid;
    logic [DEPTH-1:0]    r_ready;
    logic [FUNC_W-1:0]   r_func [DEPTH];
    logic [REG_W-1:0]    r_rd   [DEPTH];
    logic [DATA_W-1:0]   r_data [DEPTH];

    logic                r_commit_valid;
    logic [TAG_W-1:0]    r_commit_tag;
    logic [REG_W-1:0]    r_commit_rd;
    logic [DATA_W-1:0]   r_commit_data;
    logic [FUNC_W-1:0]   r_commit_func;
    logic                r_commit_add;
    logic                r_commit_mul;

    logic [TAG_W-1:0]    w_head_idx;
    logic [TAG_W-1:0]    w_tail_idx;
    logic                w_empty;
    logic                w_full;
    logic                w_alloc;
    logic                w_cdb_hit;
    logic                w_commit;
    logic [FUNC_W-1:0]   w_head_func;
    logic                w_is_add;
    logic                w_is_mul;

    assign w_head_idx  = r_head[TAG_W-1:0];
    assign w_tail_idx  = r_tail[TAG_W-1:0];
    assign w_empty     = (r_head == r_tail);
    assign w_full      = (w_head_idx == w_tail_idx) && (r_head[TAG_W] != r_tail[TAG_W]);

    // Full is judged on registered pointers only, so a same-cycle commit
    // does not open a slot until the following cycle.
    assign w_alloc     = alloc_valid && !w_full;
    // Only a pending entry accepts a result; stale or duplicate broadcasts
    // never overwrite data that may already be on its way to retirement.
    assign w_cdb_hit   = cdb_valid && r_valid[cdb_tag] && !r_ready[cdb_tag];
    assign w_commit    = r_valid[w_head_idx] && r_ready[w_head_idx];

    assign w_head_func = r_func[w_head_idx];
    assign w_is_add    = (w_head_func == FUNC_W'(0)) || (w_head_func == FUNC_W'(1));
    assign w_is_mul    = (w_head_func == FUNC_W'(2)) || (w_head_func == FUNC_W'(3));

    always_ff @(posedge clk1) begin
        if (rst || flush) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_valid        <= '0;
            r_ready        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_tag   <= '0;
            r_commit_rd    <= '0;
            r_commit_data  <= '0;
            r_commit_func  <= '0;
            r_commit_add   <= 1'b0;
            r_commit_mul   <= 1'b0;
        end else begin
            if (w_alloc) begin
                r_valid[w_tail_idx] <= 1'b1;
                r_ready[w_tail_idx] <= 1'b0;
                r_tail              <= r_tail + PTR_ONE;
            end
            if (w_cdb_hit) begin
                r_ready[cdb_tag] <= 1'b1;
            end

            r_commit_valid <= w_commit;
            r_commit_add   <= w_commit && w_is_add;
            r_commit_mul   <= w_commit && w_is_mul;
            if (w_commit) begin
                r_valid[w_head_idx] <= 1'b0;
                r_head              <= r_head + PTR_ONE;
                r_commit_tag        <= w_head_idx;
                r_commit_rd         <= r_rd[w_head_idx];
                r_commit_data       <= r_data[w_head_idx];
                r_commit_func       <= w_head_func;
            end
        end
    end

    // Payload storage needs no reset: an entry's contents are only consumed
    // once its valid/ready bits say so.
    always_ff @(posedge clk1) begin
        if (w_alloc) begin
            r_func[w_tail_idx] <= alloc_func;
            r_rd[w_tail_idx]   <= alloc_rd;
        end
        if (w_cdb_hit) begin
            r_data[cdb_tag] <= cdb_data;
        end
    end

    assign alloc_ready  = !w_full;
    assign alloc_tag    = w_tail_idx;
    assign rob_count    = r_tail - r_head;
    assign rob_empty    = w_empty;

    assign commit_valid = r_commit_valid;
    assign commit_tag   = r_commit_tag;
    assign commit_rd    = r_commit_rd;
    assign commit_data  = r_commit_data;
    assign commit_func  = r_commit_func;
    assign commit_add   = r_commit_add;
    assign commit_mul   = r_commit_mul;

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit. Expected retirements are queued by the
// stimulus thread; a monitor pops and compares on every commit pulse.
module tb_rob_commit;

    localparam int DEPTH  = 8;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam int FUNC_W = 4;

    logic              clk1;
    logic              rst;
    logic              flush;
    logic              alloc_valid;
    logic [FUNC_W-1:0] alloc_func;
    logic [REG_W-1:0]  alloc_rd;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              commit_valid;
    logic [TAG_W-1:0]  commit_tag;
    logic [REG_W-1:0]  commit_rd;
    logic [DATA_W-1:0] commit_data;
    logic [FUNC_W-1:0] commit_func;
    logic              commit_add;
    logic              commit_mul;
    logic [TAG_W:0]    rob_count;
    logic              rob_empty;

    rob_commit #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .REG_W(REG_W), .FUNC_W(FUNC_W)
    ) dut (
        .clk1(clk1), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
        .commit_data(commit_data), .commit_func(commit_func),
        .commit_add(commit_add), .commit_mul(commit_mul),
        .rob_count(rob_count), .rob_empty(rob_empty)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic [FUNC_W-1:0] func;
        logic              add;
        logic              mul;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_r;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Class strobes for func 0..7, written out by hand.
    logic [7:0] add_tbl = 8'b0000_0011;
    logic [7:0] mul_tbl = 8'b0000_1100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [TAG_W-1:0] tag, input logic [REG_W-1:0] rd,
                        input logic [DATA_W-1:0] data, input logic [FUNC_W-1:0] func,
                        input logic add, input logic mul);
        rec_t r;
        r.tag = tag; r.rd = rd; r.data = data; r.func = func; r.add = add; r.mul = mul;
        exp_q.push_back(r);
    endtask

    task automatic nxt();
        @(negedge clk1);
    endtask

    // Check the offered tag, drive one allocation, advance to the next negedge.
    task automatic alloc_chk(input logic [FUNC_W-1:0] f, input logic [REG_W-1:0] rd,
                             input int exp_tag);
        chk("alloc_tag", alloc_tag, exp_tag);
        chk("alloc_ready", alloc_ready, 1);
        alloc_valid = 1'b1;
        alloc_func  = f;
        alloc_rd    = rd;
        nxt();
    endtask

    task automatic cdb_drive(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
        nxt();
    endtask

    // Monitor: every commit pulse must match the oldest expected retirement.
    always @(negedge clk1) begin
        if (commit_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_commit: got tag %0d data 0x%0h expected no commit",
                         commit_tag, commit_data);
            end else begin
                mon_r = exp_q.pop_front();
                chk("commit_tag",  commit_tag,  mon_r.tag);
                chk("commit_rd",   commit_rd,   mon_r.rd);
                chk("commit_data", commit_data, mon_r.data);
                chk("commit_func", commit_func, mon_r.func);
                chk("commit_add",  commit_add,  mon_r.add);
                chk("commit_mul",  commit_mul,  mon_r.mul);
            end
        end else begin
            chk("idle_strobes", {commit_add, commit_mul}, 0);
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        alloc_valid = 1'b0; alloc_func = '0; alloc_rd = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        nxt();
        nxt();
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_rob_count", rob_count, 0);
        chk("rst_rob_empty", rob_empty, 1);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_commit_tag", commit_tag, 0);
        chk("rst_commit_rd", commit_rd, 0);
        chk("rst_commit_data", commit_data, 0);
        chk("rst_commit_func", commit_func, 0);
        rst = 1'b0;

        // In-order retirement with out-of-order completion.
        alloc_chk(4'h0, 4'h1, 0);
        alloc_chk(4'h2, 4'h2, 1);
        alloc_chk(4'h1, 4'h3, 2);
        alloc_valid = 1'b0;
        chk("t1_rob_count", rob_count, 3);
        chk("t1_rob_empty", rob_empty, 0);
        push(3'd0, 4'h1, 16'h0011, 4'h0, 1'b1, 1'b0);
        push(3'd1, 4'h2, 16'h0022, 4'h2, 1'b0, 1'b1);
        push(3'd2, 4'h3, 16'h0033, 4'h1, 1'b1, 1'b0);
        cdb_drive(3'd1, 16'h0022);
        chk("t1_head_blocks", commit_valid, 0);
        cdb_drive(3'd0, 16'h0011);
        chk("t1_no_bypass", commit_valid, 0);
        cdb_drive(3'd2, 16'h0033);
        cdb_valid = 1'b0;
        chk("t1_commit0", commit_valid, 1);
        nxt();
        chk("t1_commit1", commit_valid, 1);
        nxt();
        chk("t1_commit2", commit_valid, 1);
        nxt();
        chk("t1_done_valid", commit_valid, 0);
        chk("t1_done_empty", rob_empty, 1);
        chk("t1_done_count", rob_count, 0);
        chk("t1_done_tag", alloc_tag, 3);

        // Fill from tail index 3; the tail wraps through 7 -> 0.
        for (int i = 0; i < 8; i++) alloc_chk(4'(i), 4'(i + 8), (i + 3) % 8);
        chk("t2_full_ready", alloc_ready, 0);
        chk("t2_full_count", rob_count, 8);
        alloc_func = 4'hF;
        alloc_rd   = 4'hF;
        nxt();
        chk("t2_ninth_tag", alloc_tag, 3);
        chk("t2_ninth_count", rob_count, 8);
        push(3'd3, 4'h8, 16'hC3C3, 4'h0, 1'b1, 1'b0);
        cdb_drive(3'd3, 16'hC3C3);
        cdb_valid = 1'b0;
        chk("t2_ready_set_count", rob_count, 8);
        chk("t2_still_full", alloc_ready, 0);
        chk("t2_no_commit_yet", commit_valid, 0);
        nxt();
        chk("t2_commit_valid", commit_valid, 1);
        chk("t2_count_after", rob_count, 7);
        chk("t2_alloc_rejected", alloc_tag, 3);
        chk("t2_ready_again", alloc_ready, 1);
        alloc_valid = 1'b0;
        flush = 1'b1;
        nxt();
        flush = 1'b0;
        chk("t2_flush_empty", rob_empty, 1);
        chk("t2_flush_tag", alloc_tag, 0);
        chk("t2_flush_count", rob_count, 0);

        // Full lap: 8 allocs, 8 back-to-back commits, then reuse tags 0 and 1.
        for (int i = 0; i < 8; i++) alloc_chk(4'(i), 4'(i), i);
        alloc_valid = 1'b0;
        chk("t3_full_count", rob_count, 8);
        chk("t3_full_ready", alloc_ready, 0);
        for (int i = 0; i < 8; i++) begin
            if (i >= 2) chk("t3_b2b_commit", commit_valid, 1);
            push(3'(i), 4'(i), 16'(16'h0100 + i), 4'(i), add_tbl[i], mul_tbl[i]);
            cdb_drive(3'(i), 16'(16'h0100 + i));
        end
        cdb_valid = 1'b0;
        nxt();
        nxt();
        chk("t3_lap_empty", rob_empty, 1);
        chk("t3_lap_count", rob_count, 0);
        chk("t3_lap_tag", alloc_tag, 0);
        chk("t3_lap_ready", alloc_ready, 1);
        alloc_chk(4'h5, 4'h9, 0);
        alloc_chk(4'h6, 4'hA, 1);
        alloc_valid = 1'b0;
        chk("t3_wrap_count", rob_count, 2);
        chk("t3_wrap_empty", rob_empty, 0);
        chk("t3_wrap_tag", alloc_tag, 2);

        // Stray and duplicate CDB traffic.
        cdb_drive(3'd5, 16'hDEAD);
        chk("t4_invalid_count", rob_count, 2);
        chk("t4_invalid_commit", commit_valid, 0);
        cdb_drive(3'd1, 16'hAAAA);
        cdb_drive(3'd1, 16'hFFFF);
        chk("t4_dup_commit", commit_valid, 0);
        push(3'd0, 4'h9, 16'hBBBB, 4'h5, 1'b0, 1'b0);
        push(3'd1, 4'hA, 16'hAAAA, 4'h6, 1'b0, 1'b0);
        cdb_drive(3'd0, 16'hBBBB);
        cdb_valid = 1'b0;
        chk("t4_latency", commit_valid, 0);
        nxt();
        chk("t4_commit0", commit_valid, 1);
        nxt();
        chk("t4_commit1", commit_valid, 1);
        nxt();
        chk("t4_empty", rob_empty, 1);
        chk("t4_tag", alloc_tag, 2);

        // Flush with 4 entries, two of them ready; flush-cycle alloc/CDB dropped.
        alloc_chk(4'h0, 4'h1, 2);
        alloc_chk(4'h0, 4'h2, 3);
        alloc_chk(4'h0, 4'h3, 4);
        alloc_chk(4'h0, 4'h4, 5);
        alloc_valid = 1'b0;
        cdb_drive(3'd3, 16'h3333);
        cdb_drive(3'd4, 16'h4444);
        cdb_valid = 1'b0;
        chk("t5_count", rob_count, 4);
        chk("t5_no_commit", commit_valid, 0);
        flush = 1'b1; alloc_valid = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 16'h2222;
        nxt();
        flush = 1'b0; alloc_valid = 1'b0; cdb_valid = 1'b0;
        chk("t5_flush_empty", rob_empty, 1);
        chk("t5_flush_tag", alloc_tag, 0);
        chk("t5_flush_commit", commit_valid, 0);
        chk("t5_flush_count", rob_count, 0);
        nxt();
        nxt();
        chk("t5_post_commit", commit_valid, 0);
        chk("t5_post_empty", rob_empty, 1);

        // Reset mid-stream, on the edge where the head would have retired.
        alloc_chk(4'h0, 4'h1, 0);
        alloc_chk(4'h0, 4'h2, 1);
        alloc_chk(4'h0, 4'h3, 2);
        alloc_chk(4'h0, 4'h4, 3);
        alloc_valid = 1'b0;
        cdb_drive(3'd1, 16'h1111);
        cdb_drive(3'd0, 16'h0000);
        cdb_valid = 1'b0;
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        chk("t5_rst_empty", rob_empty, 1);
        chk("t5_rst_tag", alloc_tag, 0);
        chk("t5_rst_commit", commit_valid, 0);
        chk("t5_rst_count", rob_count, 0);

        // Function code outside both classes.
        alloc_chk(4'h4, 4'h5, 0);
        alloc_valid = 1'b0;
        push(3'd0, 4'h5, 16'h1234, 4'h4, 1'b0, 1'b0);
        cdb_drive(3'd0, 16'h1234);
        cdb_valid = 1'b0;
        nxt();
        chk("t6_commit", commit_valid, 1);
        nxt();
        chk("t6_empty", rob_empty, 1);

        nxt();
        nxt();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
